// File: rtl/instr_issue.sv
`default_nettype none
// ============================================================================
// Module   : instr_issue
// Purpose  : In-order instruction issue stage. Buffers upstream words in a
//            circular FIFO and forwards the head into the pipeline one per
//            cycle. A bubble is issued instead while the head reads a
//            register written by one of the last HAZ_WINDOW issue slots.
//            A halt word (all ones) is consumed without being forwarded and
//            freezes the block until reset.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1   rising-edge clock
//   rst          in   1   synchronous active-high reset
//   in_valid     in   1   upstream offers in_instr this cycle
//   in_instr     in  32   upstream instruction word
//   in_ready     out  1   block accepts in_instr this cycle
//   InstrOut     out 32   registered instruction into the pipeline (0 = bubble)
//   issue_valid  out  1   registered, InstrOut holds a real instruction
//   halted       out  1   registered, halt word has been consumed
//   stall_cnt    out 16   saturating count of hazard-bubble cycles
// ============================================================================
module instr_issue #(
  parameter int FIFO_DEPTH = 4,
  parameter int HAZ_WINDOW = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  output logic [31:0] InstrOut,
  output logic        issue_valid,
  output logic        halted,
  output logic [15:0] stall_cnt
);

  localparam int          PTR_W     = $clog2(FIFO_DEPTH);
  localparam int          CNT_W     = PTR_W + 1;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t                   state_q;
  logic [31:0]              fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q;
  logic [PTR_W-1:0]         rd_ptr_q;
  logic [CNT_W-1:0]         count_q;
  // Scoreboard: slot 0 is the most recent issue slot.
  logic [HAZ_WINDOW-1:0]    sb_vld_q;
  logic [HAZ_WINDOW*5-1:0]  sb_rd_q;
  logic [HAZ_WINDOW-1:0]    sb_vld_d;
  logic [HAZ_WINDOW*5-1:0]  sb_rd_d;
  logic [31:0]              instr_out_q;
  logic                     issue_valid_q;
  logic                     halted_q;
  logic [15:0]              stall_cnt_q;

  // --------------------------------------------------------------------------
  // FIFO status and handshake
  // --------------------------------------------------------------------------
  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic [31:0] head;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign in_ready   = !fifo_full && (state_q == ST_RUN);
  assign push       = in_valid && in_ready;
  // Head is read from storage only, so a word can never issue in the cycle
  // it is written.
  assign head       = fifo_mem_q[rd_ptr_q];

  // --------------------------------------------------------------------------
  // Head decode
  // --------------------------------------------------------------------------
  logic [5:0] head_op;
  logic [4:0] head_rd;
  logic [4:0] head_rs;
  logic [4:0] head_rt;
  logic       head_is_r;
  logic       head_is_i;
  logic       head_reads_rs;
  logic       head_reads_rt;
  logic       head_writes;
  logic       head_is_halt;

  assign head_op       = head[31:26];
  assign head_rd       = head[25:21];
  assign head_rs       = head[20:16];
  assign head_rt       = head[15:11];
  assign head_is_r     = (head_op[5:3] == 3'b010);
  assign head_is_i     = (head_op[5:3] == 3'b011);
  assign head_reads_rs = head_is_r || head_is_i;
  assign head_reads_rt = head_is_r;
  assign head_writes   = head_is_r || head_is_i;
  assign head_is_halt  = (head == HALT_WORD);

  // --------------------------------------------------------------------------
  // RAW hazard against every valid scoreboard slot. r0 gets no exemption.
  // --------------------------------------------------------------------------
  logic [HAZ_WINDOW-1:0] slot_hit;

  for (genvar k = 0; k < HAZ_WINDOW; k++) begin : g_slot
    logic [4:0] slot_rd;
    assign slot_rd     = sb_rd_q[k*5 +: 5];
    assign slot_hit[k] = sb_vld_q[k] &&
                         ((head_reads_rs && (head_rs == slot_rd)) ||
                          (head_reads_rt && (head_rt == slot_rd)));
  end

  logic hazard;
  logic pop;
  logic issue_now;
  logic take_halt;

  assign hazard    = (state_q == ST_RUN) && !fifo_empty && (|slot_hit);
  assign pop       = (state_q == ST_RUN) && !fifo_empty && !hazard;
  assign issue_now = pop && !head_is_halt;
  assign take_halt = pop && head_is_halt;

  // Scoreboard shift: the slot just issued enters at position 0; bubbles and
  // non-writing instructions enter as invalid.
  always_comb begin
    sb_vld_d = sb_vld_q;
    sb_rd_d  = sb_rd_q;
    for (int k = HAZ_WINDOW - 1; k > 0; k--) begin
      sb_vld_d[k]       = sb_vld_q[k-1];
      sb_rd_d[k*5 +: 5] = sb_rd_q[(k-1)*5 +: 5];
    end
    sb_vld_d[0]  = issue_now && head_writes;
    sb_rd_d[4:0] = head_rd;
  end

  // --------------------------------------------------------------------------
  // FIFO storage (contents need no reset; pointers/count define validity)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_mem_q[wr_ptr_q] <= in_instr;
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      sb_vld_q      <= '0;
      sb_rd_q       <= '0;
      instr_out_q   <= '0;
      issue_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          // Depth is a power of two, so pointer overflow is the modulo wrap.
          if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
          end
          if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
          end
          case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
          endcase

          sb_vld_q      <= sb_vld_d;
          sb_rd_q       <= sb_rd_d;
          instr_out_q   <= issue_now ? head : 32'h0000_0000;
          issue_valid_q <= issue_now;

          if (hazard && (stall_cnt_q != STALL_MAX)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
          end

          if (take_halt) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end
        end

        ST_HALT: begin
          // Everything else holds until reset.
          instr_out_q   <= 32'h0000_0000;
          issue_valid_q <= 1'b0;
          halted_q      <= 1'b1;
        end

        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  assign InstrOut    = instr_out_q;
  assign issue_valid = issue_valid_q;
  assign halted      = halted_q;
  assign stall_cnt   = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_issue
// Purpose  : Self-checking bench for instr_issue. Accepted words are queued
//            as expected issues and compared in order as the DUT issues them.
//            A table of instruction pairs checks hazard decode; directed
//            sequences cover backpressure/wrap, mid-operation reset, halt and
//            stall counter saturation (second instance, HAZ_WINDOW = 1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_issue;

  localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic [31:0] InstrOut;
  logic        issue_valid;
  logic        halted;
  logic [15:0] stall_cnt;

  logic        rst_s;
  logic        in_valid_s;
  logic [31:0] in_instr_s;
  logic        in_ready_s;
  logic [31:0] instr_out_s;
  logic        issue_valid_s;
  logic        halted_s;
  logic [15:0] stall_cnt_s;

  always #5 clk = ~clk;

  instr_issue #(.FIFO_DEPTH(4), .HAZ_WINDOW(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .InstrOut(InstrOut), .issue_valid(issue_valid),
    .halted(halted), .stall_cnt(stall_cnt)
  );

  instr_issue #(.FIFO_DEPTH(4), .HAZ_WINDOW(1)) u_sat (
    .clk(clk), .rst(rst_s), .in_valid(in_valid_s), .in_instr(in_instr_s),
    .in_ready(in_ready_s), .InstrOut(instr_out_s), .issue_valid(issue_valid_s),
    .halted(halted_s), .stall_cnt(stall_cnt_s)
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  logic [31:0] exp_q[$];
  int          iss_cyc[$];

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    int          stall;
  } vec_t;

  vec_t tab[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
    end
  endtask

  // One clock; afterwards any issued word is checked against the queue.
  task automatic tick();
    logic [31:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (issue_valid) begin
      iss_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_issue: got 0x%08h required no issue", InstrOut);
      end else begin
        e = exp_q.pop_front();
        chk("issue_word", InstrOut, e);
      end
    end else begin
      chk("bubble_zero", InstrOut, 32'h0);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_instr = w;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("push_ready", {31'h0, in_ready}, 32'h1);
    if (in_ready) begin
      if (w != HALT_W) exp_q.push_back(w);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk("drain_left", exp_q.size(), 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  logic [31:0] bp_w[6];
  int          exp_stall;
  int          push_cyc;

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_instr   = '0;
    rst_s      = 1'b1;
    in_valid_s = 1'b0;
    in_instr_s = '0;

    tab[0] = '{"indep_pair",     32'h7421000A, 32'h6C420002, 0};
    tab[1] = '{"raw_rtype",      32'h7421000A, 32'h54611000, 2};
    tab[2] = '{"raw_itype_rs",   32'h7421000A, 32'h7421000A, 2};
    tab[3] = '{"raw_rtype_rt",   32'h40A00000, 32'h40C72800, 2};
    tab[4] = '{"nonreg_writer",  32'h04200000, 32'h54611000, 0};
    tab[5] = '{"r0_not_exempt",  32'h60000000, 32'h40C70000, 2};
    tab[6] = '{"itype_skips_rt", 32'h7421000A, 32'h60430800, 0};

    // ---------------- reset state ----------------
    do_reset();
    chk("rst_instr_out",   InstrOut, 32'h0);
    chk("rst_issue_valid", {31'h0, issue_valid}, 32'h0);
    chk("rst_halted",      {31'h0, halted}, 32'h0);
    chk("rst_stall_cnt",   {16'h0, stall_cnt}, 32'h0);
    chk("rst_in_ready",    {31'h0, in_ready}, 32'h1);

    // ---------------- table: dependent/independent pairs ----------------
    exp_stall = 0;
    foreach (tab[i]) begin
      iss_cyc.delete();
      push_word(tab[i].a);
      push_word(tab[i].b);
      drain();
      repeat (3) tick();
      exp_stall += tab[i].stall;
      chk({tab[i].name, "_stall_cnt"}, {16'h0, stall_cnt}, exp_stall);
      chk({tab[i].name, "_issues"}, iss_cyc.size(), 32'd2);
      if (iss_cyc.size() == 2)
        chk({tab[i].name, "_gap"}, iss_cyc[1] - iss_cyc[0], 1 + tab[i].stall);
    end

    // ---------------- backpressure and pointer wrap ----------------
    // Scoreboard is held on r20 so the head (which reads r20) cannot issue.
    for (int i = 0; i < 6; i++) bp_w[i] = 32'h6014_0000 | (32'(10 + i) << 21);
    force u_dut.sb_vld_q = 2'b11;
    force u_dut.sb_rd_q  = {5'd20, 5'd20};
    iss_cyc.delete();
    for (int i = 0; i < 4; i++) push_word(bp_w[i]);
    chk("bp_full_ready", {31'h0, in_ready}, 32'h0);
    in_valid = 1'b1;
    in_instr = bp_w[4];
    repeat (3) begin
      tick();
      chk("bp_hold_ready", {31'h0, in_ready}, 32'h0);
      chk("bp_hold_issue", {31'h0, issue_valid}, 32'h0);
    end
    release u_dut.sb_vld_q;
    release u_dut.sb_rd_q;
    push_word(bp_w[4]);
    push_word(bp_w[5]);
    drain();
    chk("bp_issue_count", iss_cyc.size(), 32'd6);
    repeat (3) tick();

    // ---------------- reset while a hazard is pending, 3 queued ----------------
    push_word(32'h7421000A);
    push_word(32'h54611000);
    push_word(32'h60830000);
    push_word(32'h6C420002);
    push_word(32'h60A00000);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h11111111;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    chk("mrst_instr_out",   InstrOut, 32'h0);
    chk("mrst_issue_valid", {31'h0, issue_valid}, 32'h0);
    chk("mrst_stall_cnt",   {16'h0, stall_cnt}, 32'h0);
    chk("mrst_in_ready",    {31'h0, in_ready}, 32'h1);
    iss_cyc.delete();
    push_word(32'h6C420002);
    push_cyc = cyc;
    drain();
    chk("mrst_issue_count", iss_cyc.size(), 32'd1);
    if (iss_cyc.size() == 1) chk("mrst_latency", iss_cyc[0] - push_cyc, 32'd1);
    repeat (4) tick();
    chk("mrst_no_junk", iss_cyc.size(), 32'd1);
    chk("mrst_stall_after", {16'h0, stall_cnt}, 32'h0);

    // ---------------- halt ----------------
    do_reset();
    push_word(32'h7421000A);
    push_word(HALT_W);
    push_word(32'h6C420002);
    chk("halt_halted",   {31'h0, halted}, 32'h1);
    chk("halt_in_ready", {31'h0, in_ready}, 32'h0);
    chk("halt_a_issued", exp_q.size(), 32'd1);
    in_valid = 1'b1;
    in_instr = 32'h6C420002;
    repeat (8) begin
      tick();
      chk("halt_issue_valid", {31'h0, issue_valid}, 32'h0);
      chk("halt_hold",        {31'h0, halted}, 32'h1);
      chk("halt_ready_low",   {31'h0, in_ready}, 32'h0);
      chk("halt_stall_frz",   {16'h0, stall_cnt}, 32'h0);
    end
    in_valid = 1'b0;
    do_reset();
    chk("post_halt_rst_halted", {31'h0, halted}, 32'h0);
    chk("post_halt_rst_ready",  {31'h0, in_ready}, 32'h1);

    // ---------------- stall counter saturation (HAZ_WINDOW = 1) ----------------
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_s = 1'b0;
    force u_sat.sb_vld_q = 1'b1;
    force u_sat.sb_rd_q  = 5'd1;
    chk("sat_ready", {31'h0, in_ready_s}, 32'h1);
    in_valid_s = 1'b1;
    in_instr_s = 32'h54611000;
    @(posedge clk); #1;
    in_valid_s = 1'b0;
    for (int k = 1; k <= 65540; k++) begin
      @(posedge clk); #1;
      if (k == 1000) chk("sat_count_1000", {16'h0, stall_cnt_s}, 32'd1000);
      if (k == 65534) chk("sat_count_65534", {16'h0, stall_cnt_s}, 32'd65534);
    end
    chk("sat_stall_max",   {16'h0, stall_cnt_s}, 32'h0000FFFF);
    chk("sat_no_issue",    {31'h0, issue_valid_s}, 32'h0);
    release u_sat.sb_vld_q;
    release u_sat.sb_rd_q;
    begin
      int n;
      n = 0;
      while (!issue_valid_s && n < 10) begin
        @(posedge clk); #1;
        n++;
      end
    end
    chk("sat_release_issue", {31'h0, issue_valid_s}, 32'h1);
    chk("sat_release_word",  instr_out_s, 32'h54611000);
    chk("sat_stall_hold",    {16'h0, stall_cnt_s}, 32'h0000FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_issue.md
INSTR_ISSUE -- requirements
Module: instr_issue

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, sets the instruction buffer depth in entries (power of 2, 2..16).
REQ-002 Parameter HAZ_WINDOW, default 2, sets the number of most recently issued slots checked for RAW hazards (1..4).
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port in_valid, input, 1 bit: upstream offers in_instr this cycle.
REQ-006 Port in_instr, input, 32 bits: instruction word offered upstream.
REQ-007 Port in_ready, output, 1 bit: block can accept in_instr this cycle.
REQ-008 Port InstrOut, output, 32 bits: registered instruction driven into the pipeline's InstrIn port.
REQ-009 Port issue_valid, output, 1 bit: registered; high when InstrOut holds a real (non-bubble) instruction.
REQ-010 Port halted, output, 1 bit: registered; high once the halt word has been consumed.
REQ-011 Port stall_cnt, output, 16 bits: count of hazard-bubble cycles.

Function
REQ-012 Field decode: op = [31:26], rd = [25:21], rs = [20:16], rt = [15:11].
REQ-013 op[5:3] = 3'b010 is R-type, which reads rs and rt and writes rd.
REQ-014 op[5:3] = 3'b011 is I-type, which reads rs only and writes rd.
REQ-015 Any other op reads and writes no register; r0 is an ordinary writable register with no exemption.
REQ-016 Bubble word = 32'h00000000; halt word = 32'hFFFFFFFF.
REQ-017 A push occurs when in_valid and in_ready are both high in the same cycle; in_ready = !fifo_full && state == RUN, with no push when full even if a pop occurs the same cycle.
REQ-018 The FIFO is circular and its read/write pointers wrap modulo FIFO_DEPTH; a push and a pop in the same cycle leave the occupancy unchanged.
REQ-019 The earliest issue of a word pushed in cycle N is the InstrOut update at the end of cycle N+1, so there is no write-to-read bypass.
REQ-020 The scoreboard is a shift register of HAZ_WINDOW entries {valid, rd}; each cycle in RUN it shifts in the slot just issued, with valid = 1 only for writing instructions.
REQ-021 A hazard exists when the FIFO head reads any register equal to a valid scoreboard rd.
REQ-022 In RUN with the FIFO empty: InstrOut <= 0, issue_valid <= 0, stall_cnt unchanged.
REQ-023 In RUN with a hazard: InstrOut <= 0, issue_valid <= 0, no pop, and stall_cnt increments, saturating at 16'hFFFF.
REQ-024 In RUN with no hazard and a non-halt head: pop the head, InstrOut <= head, issue_valid <= 1.
REQ-025 In RUN with a halt word at the head: pop it, InstrOut <= 0, issue_valid <= 0, go to HALT.
REQ-026 The halt word is never forwarded to InstrOut.
REQ-027 State machine: RUN goes to HALT on consuming the halt word, and HALT goes to RUN only on rst.
REQ-028 In HALT: halted = 1, in_ready = 0, InstrOut = 0, issue_valid = 0, FIFO contents frozen, scoreboard frozen, stall_cnt frozen.
REQ-029 The hazard check covers the FIFO head only, so instructions issue strictly in order.

Reset
REQ-030 When rst is high at a clock edge, the block takes these values regardless of state or occupancy: FIFO emptied (pointers 0), scoreboard valid bits 0, state RUN.
REQ-031 The same reset edge drives InstrOut = 0, issue_valid = 0, halted = 0, stall_cnt = 0, in_ready = 1 from the next cycle.
REQ-032 A push attempted in the same cycle as rst is discarded.

Verification
REQ-033 Independent pair: push 0x7421000A then 0x6C420002 on consecutive cycles -> both issue on consecutive cycles, no bubble, stall_cnt = 0.
REQ-034 RAW hazard: push 0x7421000A then 0x54611000 with HAZ_WINDOW=2 -> InstrOut sequence 0x7421000A, 0, 0, 0x54611000, and stall_cnt = 2.
REQ-035 Backpressure and wrap: push 6 independent I-type words back-to-back with FIFO_DEPTH=4 -> in_ready drops while 4 entries are held, all 6 issue in order, and pointers wrap without loss.
REQ-036 Halt: push 0x7421000A, 0xFFFFFFFF, 0x6C420002 -> 0x7421000A issues, then halted = 1, InstrOut stays 0, 0x6C420002 is never issued, and in_ready = 0.
REQ-037 Mid-operation reset: assert rst for 1 cycle while a hazard is pending with 3 entries queued -> next cycle InstrOut = 0, stall_cnt = 0, in_ready = 1, and a freshly pushed word issues with no bubble.
REQ-038 Saturation: force 65,540 hazard cycles with a producer whose result never retires (HAZ_WINDOW=1, dependent word held via a test hook) -> stall_cnt holds at 16'hFFFF.
